// File: rtl/alu_seq.sv
// alu_seq: MIPS EX-stage ALU with single-cycle alufun ops and iterative MUL/DIV behind valid/ready handshakes.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       alufun,
   input  logic             sign,
   input  logic [1:0]       md_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] res_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic nq_q, nq_d, nr_q, nr_d, ovf_q, ovf_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] bb, alu_res, abs_a, abs_b, mul_hi, mul_lo, div_hi, div_lo;
   logic [WIDTH:0] sum, madd, dd;
   logic alu_ovf, lt, flag, last, accept;
   always_comb begin
      bb = alufun[0] ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, alufun[0]};
      lt = sign ? ($signed(a) < $signed(b)) : (a < b);
      alu_ovf = 1'b0;
      flag = 1'b0;
      alu_res = '0;
      case (alufun)
         6'b110011: flag = a == b;
         6'b110001: flag = a != b;
         6'b110101: flag = lt;
         6'b111101: flag = a[WIDTH-1] | ~|a;
         6'b111011: flag = a[WIDTH-1];
         6'b111111: flag = ~a[WIDTH-1] & |a;
         default:   flag = 1'b0;
      endcase
      case (alufun[5:4])
         2'b00: begin
            alu_res = sum[WIDTH-1:0];
            // unsigned SUB reports borrow, the inverse of the adder carry
            alu_ovf = sign ? (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]) : sum[WIDTH] ^ alufun[0];
         end
         2'b01: begin
            case (alufun)
               6'b011000: alu_res = a & b;
               6'b011110: alu_res = a | b;
               6'b010110: alu_res = a ^ b;
               6'b010001: alu_res = ~(a | b);
               6'b011010: alu_res = a;
               default:   alu_res = '0;
            endcase
         end
         2'b10: begin
            case (alufun)
               6'b100000: alu_res = b << a[SHW-1:0];
               6'b100001: alu_res = b >> a[SHW-1:0];
               6'b100011: alu_res = $signed(b) >>> a[SHW-1:0];
               default:   alu_res = '0;
            endcase
         end
         default: alu_res = {{(WIDTH-1){1'b0}}, flag};
      endcase
   end
   assign abs_a = (sign & a[WIDTH-1]) ? -a : a;
   assign abs_b = (sign & b[WIDTH-1]) ? -b : b;
   // hi_q is the running partial product / remainder, res_q the multiplier / quotient shift register
   assign madd = {1'b0, hi_q} + {1'b0, res_q[0] ? m_q : {WIDTH{1'b0}}};
   assign mul_hi = madd[WIDTH:1];
   assign mul_lo = {madd[0], res_q[WIDTH-1:1]};
   assign dd = {hi_q, res_q[WIDTH-1]} - {1'b0, m_q};
   assign div_hi = dd[WIDTH] ? {hi_q[WIDTH-2:0], res_q[WIDTH-1]} : dd[WIDTH-1:0];
   assign div_lo = {res_q[WIDTH-2:0], ~dd[WIDTH]};
   assign last = cnt_q == CW'(1);
   assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
   assign accept = in_valid & in_ready;
   always_comb begin
      state_d = state_q;
      res_d = res_q;
      hi_d = hi_q;
      m_d = m_q;
      cnt_d = cnt_q;
      nq_d = nq_q;
      nr_d = nr_q;
      ovf_d = ovf_q;
      dbz_d = dbz_q;
      case (state_q)
         MUL: begin
            {hi_d, res_d} = (last & nq_q) ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
            cnt_d = cnt_q - CW'(1);
            state_d = last ? HOLD : MUL;
         end
         DIV: begin
            res_d = (last & nq_q) ? -div_lo : div_lo;
            hi_d = (last & nr_q) ? -div_hi : div_hi;
            cnt_d = cnt_q - CW'(1);
            state_d = last ? HOLD : DIV;
         end
         HOLD: state_d = out_ready ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         ovf_d = 1'b0;
         dbz_d = 1'b0;
         hi_d = '0;
         cnt_d = CW'(WIDTH);
         nq_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
         nr_d = sign & a[WIDTH-1];
         case (md_op)
            2'b00: begin
               res_d = alu_res;
               ovf_d = alu_ovf;
               state_d = HOLD;
            end
            2'b01: begin
               res_d = abs_b;
               m_d = abs_a;
               state_d = MUL;
            end
            2'b10: begin
               if (b == '0) begin
                  res_d = '1;
                  hi_d = a;
                  dbz_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  res_d = abs_a;
                  m_d = abs_b;
                  // MIN/-1 iterates to MIN naturally; only the flag needs setting
                  ovf_d = sign & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
                  state_d = DIV;
               end
            end
            default: begin
               res_d = '0;
               state_d = HOLD;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q <= '0;
         hi_q <= '0;
         m_q <= '0;
         cnt_q <= '0;
         nq_q <= 1'b0;
         nr_q <= 1'b0;
         ovf_q <= 1'b0;
         dbz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q <= res_d;
         hi_q <= hi_d;
         m_q <= m_d;
         cnt_q <= cnt_d;
         nq_q <= nq_d;
         nr_q <= nr_d;
         ovf_q <= ovf_d;
         dbz_q <= dbz_d;
      end
   end
   assign out_valid = state_q == HOLD;
   assign res = res_q;
   assign res_hi = hi_q;
   assign zero = res_q == '0;
   assign ovf = ovf_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;
   logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, sign = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, zero, ovf, div_by_zero;
   logic [W-1:0] a = '0, b = '0, res, res_hi;
   logic [5:0] alufun = '0;
   logic [1:0] md_op = '0;
   logic [W-1:0] e_res, e_hi;
   logic e_ovf, e_dbz;
   int e_lat;
   int total = 0, bad = 0;
   logic [5:0] codes [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                              6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                              6'b110101, 6'b111101, 6'b111011, 6'b111111};

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .alufun(alufun), .sign(sign), .md_op(md_op), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .res_hi(res_hi), .zero(zero), .ovf(ovf), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [1:0] m, input logic [5:0] f, input logic s,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic [W-1:0] h,
                                 output logic o, output logic d, output int lat);
      longint sx, sy, t;
      logic [63:0] ux, uy, u;
      logic fl;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      r = '0; h = '0; o = 1'b0; d = 1'b0; lat = 1; fl = 1'b0;
      if (m == 2'd0) begin
         if (f[5:4] == 2'b00) begin
            if (s) begin
               t = f[0] ? sx - sy : sx + sy;
               r = t[31:0];
               o = (t > SMAX) || (t < SMIN);
            end else begin
               u = f[0] ? ux - uy : ux + uy;
               r = u[31:0];
               o = f[0] ? (x < y) : u[32];
            end
         end else if (f[5:4] == 2'b01) begin
            case (f)
               6'b011000: r = x & y;
               6'b011110: r = x | y;
               6'b010110: r = x ^ y;
               6'b010001: r = ~(x | y);
               6'b011010: r = x;
               default:   r = '0;
            endcase
         end else if (f[5:4] == 2'b10) begin
            case (f)
               6'b100000: r = y << x[4:0];
               6'b100001: r = y >> x[4:0];
               6'b100011: r = $signed(y) >>> x[4:0];
               default:   r = '0;
            endcase
         end else begin
            case (f)
               6'b110011: fl = x == y;
               6'b110001: fl = x != y;
               6'b110101: fl = s ? (sx < sy) : (x < y);
               6'b111101: fl = sx <= 0;
               6'b111011: fl = sx < 0;
               6'b111111: fl = sx > 0;
               default:   fl = 1'b0;
            endcase
            r = {31'b0, fl};
         end
      end else if (m == 2'd1) begin
         lat = W + 1;
         if (s) begin
            t = sx * sy;
            {h, r} = t;
         end else begin
            u = ux * uy;
            {h, r} = u;
         end
      end else if (m == 2'd2) begin
         if (y == 0) begin
            r = '1; h = x; d = 1'b1;
         end else begin
            lat = W + 1;
            if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               r = x; h = '0; o = 1'b1;
            end else if (s) begin
               t = sx / sy; r = t[31:0];
               t = sx % sy; h = t[31:0];
            end else begin
               u = ux / uy; r = u[31:0];
               u = ux % uy; h = u[31:0];
            end
         end
      end
   endfunction

   task automatic start(input logic [1:0] m, input logic [5:0] f, input logic s,
                        input logic [W-1:0] x, input logic [W-1:0] y, input logic rel);
      int n;
      @(negedge clk);
      md_op = m; alufun = f; sign = s; a = x; b = y; in_valid = 1'b1; out_ready = rel;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = $urandom; b = $urandom; alufun = 6'($urandom); md_op = 2'($urandom); sign = 1'($urandom);
   endtask

   task automatic finish(input int stall, input logic keep);
      int n;
      logic rdy;
      n = 1;
      rdy = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) rdy = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, e_lat);
      chk("res", res, e_res);
      chk("res_hi", res_hi, e_hi);
      chk("zero", zero, e_res == 0);
      chk("ovf", ovf, e_ovf);
      chk("dbz", div_by_zero, e_dbz);
      chk("busy_rdy", rdy, 0);
      repeat (stall) begin
         @(posedge clk);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_res", {res_hi, res}, {e_hi, e_res});
         chk("hold_rdy", in_ready, 0);
      end
      if (!keep) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic op(input logic [1:0] m, input logic [5:0] f, input logic s, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int stall, input logic rel, input logic keep);
      model(m, f, s, x, y, e_res, e_hi, e_ovf, e_dbz, e_lat);
      start(m, f, s, x, y, rel);
      finish(stall, keep);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: pick = '0;
         1: pick = 32'd1;
         2: pick = '1;
         3: pick = 32'h80000000;
         4: pick = 32'h7FFFFFFF;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [1:0] m;
      int k;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_hi", res_hi, 0);
      chk("rst_zero", zero, 1);
      chk("rst_ovf", ovf, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy", in_ready, 1);
      op(2'd0, 6'b000000, 1'b1, 32'h7FFFFFFF, 32'd1, 0, 1'b0, 1'b0);
      op(2'd1, 6'b000000, 1'b1, -32'sd3, 32'd5, 0, 1'b0, 1'b0);
      op(2'd2, 6'b000000, 1'b1, -32'sd7, 32'd2, 0, 1'b0, 1'b0);
      op(2'd2, 6'b000000, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
      op(2'd2, 6'b000000, 1'b0, 32'h1234, 32'd0, 0, 1'b0, 1'b0);
      op(2'd3, 6'b011110, 1'b0, 32'hFF, 32'hF0, 0, 1'b0, 1'b0);
      op(2'd0, 6'b100000, 1'b0, 32'd4, 32'd1, 5, 1'b0, 1'b1);
      op(2'd0, 6'b000001, 1'b0, 32'd10, 32'd3, 0, 1'b1, 1'b0);
      start(2'd1, 6'b000000, 1'b1, 32'd1234, 32'd5678, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_res", {res_hi, res}, 64'd0);
      chk("mrst_zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_rdy", in_ready, 1);
      op(2'd0, 6'b000000, 1'b0, 32'd2, 32'd3, 0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         m = k < 5 ? 2'd0 : k < 7 ? 2'd1 : k < 9 ? 2'd2 : 2'd3;
         op(m, $urandom_range(0, 3) == 0 ? 6'($urandom) : codes[$urandom_range(0, 15)], 1'($urandom),
            pick(), pick(), $urandom_range(0, 2), 1'b0, 1'b0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
